ddr_rd_arbiter: RTL
===================

// Module: ddr_rd_arbiter
// PURPOSE
//  Shares the single axi_ctrl DDR read port between two requesters: m0 = hdmi_out display fetch (high priority)
//  and m1 = object-recognition frame reader. One burst in flight at a time; grant held until all beats return.
//  Sits in the ddr_clk_100M domain between the requesters and axi_ctrl (rd_req/rd_addr/arlen/rd_busy/rd_data/rdata_valid).
// PARAMETERS
//  ADDR_W        28   DDR controller address width (= CTRL_ADDR_WIDTH)
//  DATA_W        256  read beat width (= MEM_DQ_WIDTH*8)
//  LEN_W         4    burst length field; beats = arlen+1 (1..16)
//  STARVE_LIMIT  8    consecutive m0 grants while m1 pending before m1 is forced (anti-starve only)
// PORTS
//  ddr_clk      in   1       clock, all logic on this edge
//  rstn         in   1       async active-low reset
//  m0_req       in   1       display request; m0_addr/m0_len held stable until m0_ack
//  m0_addr      in   ADDR_W  m0 burst start address
//  m0_len       in   LEN_W   m0 burst length-1
//  m0_ack       out  1       1-cycle pulse: m0 request accepted by arbiter
//  m0_rvalid    out  1       rdata_valid qualified for m0
//  m1_req/m1_addr/m1_len/m1_ack/m1_rvalid    same as m0, for recognition reader
//  m_rdata      out  DATA_W  rd_data broadcast to both requesters (combinational pass-through)
//  rd_req       out  1       to axi_ctrl: read request
//  rd_addr      out  ADDR_W  to axi_ctrl: latched address of granted burst
//  arlen        out  LEN_W   to axi_ctrl: latched length of granted burst
//  rd_busy      in   1       from axi_ctrl: read in progress
//  rd_data      in   DATA_W  from axi_ctrl
//  rdata_valid  in   1       from axi_ctrl: one beat per cycle when high
//  owner        out  1       current/last grant owner (0=m0, 1=m1), debug
//  err_stray    out  1       1-cycle pulse: rdata_valid seen while IDLE/ISSUE
// BEHAVIOUR
//  Reset: state=IDLE; rd_req,m0_ack,m1_ack,m0_rvalid,m1_rvalid,err_stray=0; rd_addr,arlen,beat_cnt,starve_cnt=0; owner=0.
//  FSM IDLE -> ISSUE -> DATA -> IDLE.
//  IDLE: if !rd_busy and (m0_req|m1_req): pick winner, latch addr/len into rd_addr/arlen, set owner,
//   pulse winner's ack same cycle as transition, go ISSUE. rd_busy high in IDLE -> wait (no grant).
//  Priority: m0 wins when both request; m1 wins only when m0_req=0 (anti-starve override below).
//  ISSUE: rd_req=1, rd_addr/arlen stable; on rd_busy=1 drop rd_req next cycle, go DATA. Min 1 cycle in ISSUE.
//  DATA: each rdata_valid increments beat_cnt and raises m<owner>_rvalid same cycle (comb AND with owner);
//   beat where beat_cnt==arlen -> clear beat_cnt, go IDLE. Next grant needs rd_busy=0 (checked in IDLE).
//  Beats in DATA beyond arlen+1 impossible by FSM; rdata_valid in IDLE/ISSUE -> dropped, err_stray pulses, no rvalid.
//  Ack asserted exactly once per accepted request; requester must deassert or present new request after ack.
//  Simultaneous: new req arriving while last beat returns is considered next IDLE cycle (1-cycle bubble, fixed).
//  Reset mid-burst: everything returns to reset values immediately; axi_ctrl is reset from same rstn.
// CONFIGURATION
//  `RD_ARB_ANTI_STARVE_EN defined: starve_cnt (clog2(STARVE_LIMIT+1) bits) ++ on each m0 grant while m1_req=1,
//   cleared on any m1 grant or when m1_req=0 at grant; when starve_cnt==STARVE_LIMIT and both request, m1 wins.
//  Not defined: strict m0 priority, starve_cnt absent, m1 may starve indefinitely.
// STRUCTURE
//  Shared package/include: state encodings (ST_IDLE=0,ST_ISSUE=1,ST_DATA=2), requester ids, default widths
//   from p_ddr.v (CTRL_ADDR_WIDTH, MEM_DQ_WIDTH). One sub-module natural: rd_arb_pick (comb winner select
//   + starve counter), rest in top FSM. No FIFOs; data is not stored.
// TESTING
//  T1 m0 only, len=3, addr=0x100: m0_ack 1 cycle, rd_req until rd_busy, 4 m0_rvalid, 0 m1_rvalid, back to IDLE.
//  T2 m0,m1 same cycle (len 0 and 7): m0 granted first (owner=0), then m1 gets 8 beats; rd_addr switches correctly.
//  T3 m1 burst len=15 in DATA, m0_req rises: m0 waits until 16th beat + rd_busy=0, then granted.
//  T4 rdata_valid pulsed in IDLE: err_stray=1 one cycle, no rvalid, state stays IDLE.
//  T5 rstn low during DATA beat 5 of 8: all outputs zero asynchronously; after release, fresh m1 req served normally.
//  T6 ANTI_STARVE_EN, STARVE_LIMIT=8, both reqs continuous: 8 m0 grants then 1 m1 grant, repeating; off: m1 never.

Source files
------------

// File: rtl/ddr_rd_arbiter_pkg.sv
// ddr_rd_arbiter_pkg
//   Shared definitions for the DDR read-port arbiter: FSM state encoding,
//   requester ids and default widths taken from the DDR controller setup
//   (CTRL_ADDR_WIDTH, MEM_DQ_WIDTH).
//   No ports (package).
package ddr_rd_arbiter_pkg;

    localparam int CTRL_ADDR_WIDTH = 28;
    localparam int MEM_DQ_WIDTH    = 32;
    localparam int DEF_DATA_W      = MEM_DQ_WIDTH * 8;
    localparam int DEF_LEN_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } rd_arb_state_t;

    typedef enum logic {
        REQ_M0 = 1'b0,   // hdmi_out display fetch, high priority
        REQ_M1 = 1'b1    // object-recognition frame reader
    } req_id_t;

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// ddr_rd_arbiter_if
//   One requester's read-request channel into the arbiter.
//   Handshake: req acts as valid; addr/len must stay stable while req is
//   high until ack. ack is a single-cycle accept pulse (ready) issued in the
//   cycle the arbiter grants; the transfer happens on that clock edge and the
//   requester then drops req or presents its next request. rvalid marks
//   read beats on the shared data bus that belong to this requester.
//   Signals:
//     req    requester -> arbiter  burst request
//     addr   requester -> arbiter  burst start address (ADDR_W)
//     len    requester -> arbiter  burst length - 1 (LEN_W)
//     ack    arbiter -> requester  accept pulse
//     rvalid arbiter -> requester  read beat valid for this requester
//   Modports: master = requester side, slave = arbiter side.
interface ddr_rd_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 4
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              ack;
    logic              rvalid;

    modport master (output req, output addr, output len, input ack, input rvalid);
    modport slave  (input req, input addr, input len, output ack, output rvalid);
endinterface

// File: rtl/ddr_rd_arbiter_pick.sv
// ddr_rd_arbiter_pick
//   Combinational winner select between m0 and m1, plus the optional
//   anti-starvation counter (enabled by defining RD_ARB_ANTI_STARVE_EN).
//   Without the macro m0 has strict priority and m1 may starve.
//   Ports:
//     clk, rstn   clock, async active-low reset (counter only)
//     m0_req      m0 request
//     m1_req      m1 request
//     grant       a grant is taken this cycle (counter update strobe)
//     win_id      winning requester, valid whenever either request is high
module ddr_rd_arbiter_pick
    import ddr_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    m0_req,
    input  logic    m1_req,
    input  logic    grant,
    output req_id_t win_id
);

`ifdef RD_ARB_ANTI_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_m1;

    // m1 overrides m0 once m0 has won STARVE_LIMIT grants back to back
    // while m1 was waiting.
    assign force_m1 = (starve_cnt == CNT_W'(STARVE_LIMIT)) && m0_req && m1_req;
    assign win_id   = (m0_req && !force_m1) ? REQ_M0 : REQ_M1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (win_id == REQ_M1 || !m1_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_pick;

    assign win_id      = m0_req ? REQ_M0 : REQ_M1;
    assign unused_pick = &{1'b0, clk, rstn, m1_req, grant, STARVE_LIMIT[0]};
`endif

endmodule

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter
//   Shares the single axi_ctrl DDR read port between m0 (hdmi_out display
//   fetch, high priority) and m1 (object-recognition frame reader). One burst
//   in flight; the grant is held until all arlen+1 beats have returned.
//   FSM: IDLE -> ISSUE -> DATA -> IDLE.
//   Optional macro: RD_ARB_ANTI_STARVE_EN (forces an m1 grant after
//   STARVE_LIMIT consecutive m0 grants while m1 waits).
//   Ports:
//     ddr_clk, rstn     clock, async active-low reset
//     m0, m1            requester channels (ddr_rd_arbiter_if.slave)
//     m_rdata           rd_data broadcast to both requesters
//     rd_req            read request to axi_ctrl
//     rd_addr, arlen    latched address / length of the granted burst
//     rd_busy           axi_ctrl read in progress
//     rd_data           read beat data from axi_ctrl
//     rdata_valid       read beat valid from axi_ctrl
//     owner             current/last grant owner (0=m0, 1=m1)
//     err_stray         pulse: rdata_valid outside DATA
//     state_dbg         FSM state, debug
module ddr_rd_arbiter
    import ddr_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W       = CTRL_ADDR_WIDTH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                ddr_clk,
    input  logic                rstn,
    ddr_rd_arbiter_if.slave     m0,
    ddr_rd_arbiter_if.slave     m1,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [LEN_W-1:0]    arlen,
    input  logic                rd_busy,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rdata_valid,
    output logic                owner,
    output logic                err_stray,
    output rd_arb_state_t       state_dbg
);

    rd_arb_state_t    state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q;
    req_id_t          win_id;
    logic             grant;
    logic             in_data;
    logic             last_beat;

    // A new grant is only taken in IDLE with the controller idle; a request
    // arriving during the final beat therefore waits one bubble cycle.
    assign grant     = (state_q == ST_IDLE) && !rd_busy && (m0.req || m1.req);
    assign in_data   = (state_q == ST_DATA);
    assign last_beat = in_data && rdata_valid && (beat_cnt_q == arlen);

    ddr_rd_arbiter_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk    (ddr_clk),
        .rstn   (rstn),
        .m0_req (m0.req),
        .m1_req (m1.req),
        .grant  (grant),
        .win_id (win_id)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant)     state_d = ST_ISSUE;
            ST_ISSUE: if (rd_busy)   state_d = ST_DATA;
            ST_DATA:  if (last_beat) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rd_addr    <= '0;
            arlen      <= '0;
            owner      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rd_addr <= (win_id == REQ_M1) ? m1.addr : m0.addr;
                arlen   <= (win_id == REQ_M1) ? m1.len  : m0.len;
                owner   <= win_id;
            end
            if (in_data && rdata_valid) begin
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + LEN_W'(1);
            end
        end
    end

    assign m0.ack    = grant && (win_id == REQ_M0);
    assign m1.ack    = grant && (win_id == REQ_M1);
    assign rd_req    = (state_q == ST_ISSUE);
    // Beats are routed to the owner only while in DATA; anything else is
    // dropped and flagged.
    assign m0.rvalid = in_data && rdata_valid && (owner == REQ_M0);
    assign m1.rvalid = in_data && rdata_valid && (owner == REQ_M1);
    assign err_stray = rdata_valid && !in_data;
    assign m_rdata   = rd_data;
    assign state_dbg = state_q;

endmodule
